// File: rtl/biss_pkg.sv
// Shared BiSS-C definitions: frame states, CRC6 constants and the latched frame payload.
package biss_pkg;

  localparam int unsigned CRC_W    = 6;
  localparam logic [6:0]  CRC_POLY = 7'h43;
  localparam int unsigned MAX_BITS = 32;
  localparam int unsigned CNT_W    = $clog2(MAX_BITS);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WAIT_ACK,
    ST_ACK,
    ST_START,
    ST_CDS,
    ST_DATA,
    ST_ERR,
    ST_WARN,
    ST_CRC,
    ST_TIMEOUT
  } biss_state_e;

  typedef struct packed {
    logic [MAX_BITS-1:0] posn;
    logic [CNT_W-1:0]    msb;
    logic                err;
    logic                warn;
  } biss_frame_t;

  // Position length outside 1..32 falls back to the full 32-bit word.
  function automatic logic [CNT_W-1:0] bits_to_msb(input logic [7:0] bits);
    if (bits == 8'd0 || bits > 8'(MAX_BITS)) return CNT_W'(MAX_BITS - 1);
    return CNT_W'(bits - 8'd1);
  endfunction

endpackage

// File: rtl/biss_slave_if.sv
// Encoder-side bus of the BiSS-C slave: position inputs, MA clock, SLO data and status.
interface biss_slave_if;

  logic [7:0]                    BITS;
  logic [biss_pkg::MAX_BITS-1:0] posn_i;
  logic                          enc_err_i;
  logic                          enc_warn_i;
  logic                          biss_sck_i;
  logic                          biss_dat_o;
  logic                          busy_o;
  logic                          frame_done_o;
  logic                          frame_abort_o;

  modport slave (
    input  BITS, posn_i, enc_err_i, enc_warn_i, biss_sck_i,
    output biss_dat_o, busy_o, frame_done_o, frame_abort_o
  );

  modport master (
    output BITS, posn_i, enc_err_i, enc_warn_i, biss_sck_i,
    input  biss_dat_o, busy_o, frame_done_o, frame_abort_o
  );

endinterface

// File: rtl/biss_crc6.sv
// Serial CRC6 (x^6+x+1, init 0), one bit per enable; shared with the sniffer/master checkers.
module biss_crc6
  import biss_pkg::*;
(
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             clr,
  input  logic             en,
  input  logic             din,
  output logic [CRC_W-1:0] crc
);

  logic fb;

  assign fb = crc[CRC_W-1] ^ din;

  always_ff @(posedge clk_i) begin
    if (reset_i || clr) begin
      crc <= '0;
    end else if (en) begin
      crc <= {crc[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY[CRC_W-1:0] : '0);
    end
  end

endmodule

// File: rtl/biss_slave.sv
// BiSS-C slave / encoder emulator: serialises a latched position frame on SLO, clocked by MA.
module biss_slave
  import biss_pkg::*;
#(
  parameter int unsigned TIMEOUT = 2500
) (
  input logic         clk_i,
  input logic         reset_i,
  biss_slave_if.slave bus
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  logic             ma_meta, ma_sync, ma_prev, rise_q, fall_q;
  biss_state_e      state_q, state_d;
  biss_frame_t      frame_q, frame_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_m1;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             dat_q, dat_d, busy_q, busy_d;
  logic             done_q, done_d, abort_q, abort_d;
  logic             crc_clr, crc_en, crc_din;
  logic [CRC_W-1:0] crc;
  logic             ma_edge, tmo_hit;

  // MA is idle high, so the synchroniser resets high to avoid a phantom fall.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ma_meta <= 1'b1;
      ma_sync <= 1'b1;
      ma_prev <= 1'b1;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      ma_meta <= bus.biss_sck_i;
      ma_sync <= ma_meta;
      ma_prev <= ma_sync;
      rise_q  <= ma_sync & ~ma_prev;
      fall_q  <= ~ma_sync & ma_prev;
    end
  end

  assign ma_edge = rise_q | fall_q;
  assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT - 1));
  assign cnt_m1  = cnt_q - CNT_W'(1);

  biss_crc6 u_crc (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clr     (crc_clr),
    .en      (crc_en),
    .din     (crc_din),
    .crc     (crc)
  );

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    dat_d   = dat_q;
    done_d  = 1'b0;
    abort_d = 1'b0;
    crc_clr = 1'b0;
    crc_en  = 1'b0;
    crc_din = 1'b0;

    // One counter serves as stall watchdog mid-frame and as the end-of-frame timeout.
    if (ma_edge) begin
      tmo_d = '0;
    end else if ((state_q == ST_TIMEOUT) ? ma_prev : (state_q != ST_IDLE)) begin
      tmo_d = tmo_q + TMO_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        tmo_d = '0;
        dat_d = 1'b1;
        if (fall_q) begin
          frame_d.posn = bus.posn_i;
          frame_d.msb  = bits_to_msb(bus.BITS);
          frame_d.err  = bus.enc_err_i;
          frame_d.warn = bus.enc_warn_i;
          cnt_d        = '0;
          crc_clr      = 1'b1;
          state_d      = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: if (rise_q) begin
        state_d = ST_ACK;
        dat_d   = 1'b0;
      end
      ST_ACK: if (rise_q) begin
        state_d = ST_START;
        dat_d   = 1'b1;
      end
      ST_START: if (rise_q) begin
        state_d = ST_CDS;
        dat_d   = 1'b0;
      end
      ST_CDS: if (rise_q) begin
        state_d = ST_DATA;
        cnt_d   = frame_q.msb;
        dat_d   = frame_q.posn[frame_q.msb];
        crc_en  = 1'b1;
        crc_din = frame_q.posn[frame_q.msb];
      end
      ST_DATA: if (rise_q) begin
        crc_en = 1'b1;
        if (cnt_q == '0) begin
          state_d = ST_ERR;
          dat_d   = ~frame_q.err;
          crc_din = ~frame_q.err;
        end else begin
          cnt_d   = cnt_m1;
          dat_d   = frame_q.posn[cnt_m1];
          crc_din = frame_q.posn[cnt_m1];
        end
      end
      ST_ERR: if (rise_q) begin
        state_d = ST_WARN;
        dat_d   = ~frame_q.warn;
        crc_en  = 1'b1;
        crc_din = ~frame_q.warn;
      end
      ST_WARN: if (rise_q) begin
        state_d = ST_CRC;
        cnt_d   = CNT_W'(CRC_W - 1);
        dat_d   = ~crc[CRC_W-1];
      end
      ST_CRC: if (rise_q) begin
        if (cnt_q == '0) begin
          state_d = ST_TIMEOUT;
          dat_d   = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_m1;
          dat_d = ~crc[3'(cnt_m1)];
        end
      end
      ST_TIMEOUT: begin
        dat_d = 1'b0;
        if (!ma_edge && ma_prev && tmo_hit) begin
          state_d = ST_IDLE;
          dat_d   = 1'b1;
          tmo_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        dat_d   = 1'b1;
      end
    endcase

    // A stalled master abandons the frame; an MA edge on the same cycle wins.
    if (state_q != ST_IDLE && state_q != ST_TIMEOUT && !ma_edge && tmo_hit) begin
      state_d = ST_IDLE;
      dat_d   = 1'b1;
      tmo_d   = '0;
      abort_d = 1'b1;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      frame_q <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      dat_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      dat_q   <= dat_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      abort_q <= abort_d;
    end
  end

  assign bus.biss_dat_o    = dat_q;
  assign bus.busy_o        = busy_q;
  assign bus.frame_done_o  = done_q;
  assign bus.frame_abort_o = abort_q;

endmodule
